// File: rtl/module_multiword_adder_seq.sv
// Sequential multi-precision adder: adds two NWORDS*RCAWIDE-bit operands one
// RCAWIDE-bit slice per cycle through a single ripple-carry adder, chaining
// the carry through a register. Valid/ready handshakes on input and output.

// Pure RCAWIDE-bit ripple-carry adder built from bit-level full adders.
module module_ripple_carry_adder #(
  parameter int RCAWIDE = 8
) (
  input  logic [RCAWIDE-1:0] a_i,
  input  logic [RCAWIDE-1:0] b_i,
  input  logic               carry_i,
  output logic [RCAWIDE-1:0] sum_o,
  output logic               carry_o
);

  logic [RCAWIDE:0] c;

  assign c[0] = carry_i;

  for (genvar i = 0; i < RCAWIDE; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[RCAWIDE];

endmodule

module module_multiword_adder_seq #(
  parameter int RCAWIDE = 8,
  parameter int NWORDS  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [NWORDS*RCAWIDE-1:0] a_i,
  input  logic [NWORDS*RCAWIDE-1:0] b_i,
  input  logic                      carry_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NWORDS*RCAWIDE-1:0] sum_o,
  output logic                      carry_o
);

  localparam int W     = NWORDS * RCAWIDE;
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  logic [RCAWIDE-1:0] rca_a, rca_b, rca_sum;
  logic               rca_cout;
  logic               accept;
  logic               last_word;

  // The adder always looks at the currently indexed slice of the latched operands.
  assign rca_a     = a_q[idx_q*RCAWIDE +: RCAWIDE];
  assign rca_b     = b_q[idx_q*RCAWIDE +: RCAWIDE];
  assign accept    = valid_i && ready_o;
  assign last_word = (idx_q == LAST_IDX);

  module_ripple_carry_adder #(
    .RCAWIDE (RCAWIDE)
  ) u_rca (
    .a_i     (rca_a),
    .b_i     (rca_b),
    .carry_i (cy_q),
    .sum_o   (rca_sum),
    .carry_o (rca_cout)
  );

  // State and datapath registers; reset clears everything so an aborted add leaves no trace.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: accept -> one ADD cycle per word -> hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = ADD;
      ADD:     if (last_word) state_d = DONE;
      DONE:    if (ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next values: latch operands on accept, write one sum slice per ADD cycle.
  always_comb begin
    idx_d   = idx_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = a_i;
          b_d   = b_i;
          cy_d  = carry_i;
          idx_d = '0;
        end
      end
      ADD: begin
        sum_d[idx_q*RCAWIDE +: RCAWIDE] = rca_sum;
        cy_d = rca_cout;
        if (last_word) begin
          cout_d  = rca_cout;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (ready_i) valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: ready only in IDLE and never while reset is asserted.
  always_comb begin
    ready_o = rst_n_i && (state_q == IDLE);
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = cout_q;

endmodule

// File: tb/tb_module_multiword_adder_seq.sv
// Self-checking bench for module_multiword_adder_seq: directed scenarios plus
// randomized operations checked against a plain-arithmetic reference sum.
module tb_module_multiword_adder_seq;

  localparam int RCAWIDE = 8;
  localparam int NWORDS  = 4;
  localparam int W       = NWORDS * RCAWIDE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;

  int n_cmp = 0;
  int n_err = 0;

  module_multiword_adder_seq #(
    .RCAWIDE (RCAWIDE),
    .NWORDS  (NWORDS)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

  always #5 clk = ~clk;

  // Reference: full-width sum of the operands plus carry-in.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for exactly one accept edge (caller ensures IDLE).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    a_i = a; b_i = b; carry_i = cin; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; carry_i = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b want 0", ready_o); end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++;
    if ({carry_o, sum_o} !== {1'b0, {W{1'b0}}})
      begin n_err++; $display("FAIL reset_outputs: got %b_%h want 0_0", carry_o, sum_o); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_carry_ripple();
    logic [W:0] exp;
    exp = ref_sum(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL ripple_ready_before: got %b want 1", ready_o); end
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    for (int k = 1; k <= NWORDS; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== (k == NWORDS))
        begin n_err++; $display("FAIL ripple_latency_k%0d: got %b want %b", k, valid_o, (k == NWORDS)); end
    end
    n_cmp++;
    if ({carry_o, sum_o} !== exp)
      begin n_err++; $display("FAIL ripple_result: got %b_%h want %b_%h", carry_o, sum_o, exp[W], exp[W-1:0]); end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01)
      begin n_err++; $display("FAIL ripple_handshake: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
  endtask

  task automatic test_basic();
    logic [W:0] exp;
    exp = ref_sum(32'h1234_5678, 32'h1111_1111, 1'b1);
    issue(32'h1234_5678, 32'h1111_1111, 1'b1);
    n_cmp++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_after_accept: got %b want 0", ready_o); end
    for (int k = 1; k <= NWORDS; k++) begin
      tick();
      n_cmp++;
      if (ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_busy_k%0d: got %b want 0", k, ready_o); end
    end
    n_cmp++;
    if ({valid_o, carry_o, sum_o} !== {1'b1, exp})
      begin n_err++; $display("FAIL basic_result: got v=%b %b_%h want v=1 %b_%h",
                               valid_o, carry_o, sum_o, exp[W], exp[W-1:0]); end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle: got %b want 1", ready_o); end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    exp = ref_sum(32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    repeat (NWORDS) tick();
    // new operands offered while busy must be ignored
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; carry_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({valid_o, ready_o, carry_o, sum_o} !== {2'b10, exp})
        begin n_err++; $display("FAIL backpressure_hold_k%0d: got v=%b r=%b %b_%h want v=1 r=0 %b_%h",
                                 k, valid_o, ready_o, carry_o, sum_o, exp[W], exp[W-1:0]); end
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01)
      begin n_err++; $display("FAIL backpressure_release: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
  endtask

  task automatic test_reset_mid_add();
    logic [W:0] exp;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({valid_o, ready_o, carry_o, sum_o} !== {2'b01, 1'b0, {W{1'b0}}})
      begin n_err++; $display("FAIL midreset_state: got v=%b r=%b %b_%h want v=0 r=1 0_0",
                               valid_o, ready_o, carry_o, sum_o); end
    // no stray result may appear after the abort
    for (int k = 0; k < NWORDS + 1; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL midreset_no_valid_k%0d: got %b want 0", k, valid_o); end
    end
    exp = ref_sum(32'd5, 32'd7, 1'b0);
    issue(32'd5, 32'd7, 1'b0);
    repeat (NWORDS) tick();
    n_cmp++;
    if ({valid_o, carry_o, sum_o} !== {1'b1, exp})
      begin n_err++; $display("FAIL midreset_fresh_op: got v=%b %b_%h want v=1 %b_%h",
                               valid_o, carry_o, sum_o, exp[W], exp[W-1:0]); end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         cin;
    logic [W:0]   exp;
    int           t;
    int           lat;
    int           stall;
    for (int op = 0; op < 200; op++) begin
      valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      a_i = a; b_i = b; carry_i = cin; valid_i = 1'b1;
      t = 0;
      while (ready_o !== 1'b1 && t < 20) begin tick(); t++; end
      if (ready_o !== 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL random_ready_timeout op%0d: got %b want 1", op, ready_o);
        break;
      end
      exp = ref_sum(a, b, cin);
      tick();
      // garbage offers and stray ready_i during the add must not matter
      valid_i = 1'(~valid_o & 1'($urandom_range(0, 1)));
      a_i = $urandom; b_i = $urandom; carry_i = 1'($urandom_range(0, 1));
      lat = 0;
      while (valid_o !== 1'b1 && lat < 20) begin
        ready_i = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      valid_i = 1'b0;
      ready_i = 1'b0;
      n_cmp++;
      if (lat != NWORDS) begin
        n_err++;
        $display("FAIL random_latency op%0d: got %0d want %0d", op, lat, NWORDS);
        if (valid_o !== 1'b1) break;
      end
      stall = $urandom_range(0, 4);
      for (int s = 0; s < stall; s++) begin
        tick();
        n_cmp++;
        if ({valid_o, ready_o, carry_o, sum_o} !== {2'b10, exp})
          begin n_err++; $display("FAIL random_stall op%0d: got v=%b r=%b %b_%h want v=1 r=0 %b_%h",
                                   op, valid_o, ready_o, carry_o, sum_o, exp[W], exp[W-1:0]); end
      end
      n_cmp++;
      if ({valid_o, carry_o, sum_o} !== {1'b1, exp})
        begin n_err++; $display("FAIL random_result op%0d: got v=%b %b_%h want v=1 %b_%h (a=%h b=%h c=%b)",
                                 op, valid_o, carry_o, sum_o, exp[W], exp[W-1:0], a, b, cin); end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      n_cmp++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL random_single_handshake op%0d: got %b want 0", op, valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_basic();
    test_backpressure();
    test_reset_mid_add();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
